fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_fetch_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch: reads an instruction one byte per accepted memory
// handshake, decodes its fields, and publishes them through shadow registers at DONE.
module fetch_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    input  logic        mem_err,
    output logic        busy,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        REGS,
        CONST,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] pc_q;
    logic [63:0] addr_q;
    logic [3:0]  len_q;
    logic [2:0]  cnt_q;
    logic [3:0]  work_icode;
    logic [3:0]  work_ifun;
    logic [3:0]  work_ra;
    logic [3:0]  work_rb;
    logic [63:0] work_valc;

    logic        commit_ok;
    logic        abort;
    logic [3:0]  fin_icode;
    logic [3:0]  fin_ifun;
    logic [3:0]  fin_ra;
    logic [3:0]  fin_rb;
    logic [63:0] fin_valc;
    logic [3:0]  fin_len;
    logic [3:0]  byte0_len;
    logic [63:0] valc_merged;

    // Total instruction length in bytes, selected by the opcode nibble.
    function automatic logic [3:0] instr_len(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
            4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
            4'h7, 4'h8:             instr_len = 4'd9;
            default:                instr_len = 4'd1;
        endcase
    endfunction

    assign byte0_len = instr_len(mem_data[7:4]);
    assign mem_addr  = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        commit_ok   = 1'b0;
        abort       = 1'b0;
        mem_req     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        fin_icode   = work_icode;
        fin_ifun    = work_ifun;
        fin_ra      = work_ra;
        fin_rb      = work_rb;
        fin_valc    = work_valc;
        fin_len     = len_q;
        valc_merged = work_valc;
        valc_merged[{cnt_q, 3'b000} +: 8] = mem_data;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BYTE0;
                end
            end
            BYTE0: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    if (mem_err) begin
                        abort      = 1'b1;
                        state_next = DONE;
                    end else begin
                        fin_icode = mem_data[7:4];
                        fin_ifun  = mem_data[3:0];
                        fin_len   = byte0_len;
                        case (byte0_len)
                            4'd1: begin
                                commit_ok  = 1'b1;
                                state_next = DONE;
                            end
                            4'd9:    state_next = CONST;
                            default: state_next = REGS;
                        endcase
                    end
                end
            end
            REGS: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    if (mem_err) begin
                        abort      = 1'b1;
                        state_next = DONE;
                    end else begin
                        fin_ra = mem_data[7:4];
                        fin_rb = mem_data[3:0];
                        if (len_q == 4'd10) begin
                            state_next = CONST;
                        end else begin
                            commit_ok  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
            end
            CONST: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    if (mem_err) begin
                        abort      = 1'b1;
                        state_next = DONE;
                    end else begin
                        fin_valc = valc_merged;
                        if (cnt_q == 3'd7) begin
                            commit_ok  = 1'b1;
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers collect the partial instruction; the visible outputs only
    // change when a fetch finishes or aborts, so they stay stable mid-fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= 64'd0;
            addr_q      <= 64'd0;
            len_q       <= 4'd1;
            cnt_q       <= 3'd0;
            work_icode  <= 4'h0;
            work_ifun   <= 4'h0;
            work_ra     <= 4'hF;
            work_rb     <= 4'hF;
            work_valc   <= 64'd0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 64'd0;
            valP        <= 64'd0;
            instr_valid <= 1'b1;
            imem_error  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                pc_q       <= PC;
                addr_q     <= PC;
                len_q      <= 4'd1;
                cnt_q      <= 3'd0;
                work_icode <= 4'h0;
                work_ifun  <= 4'h0;
                work_ra    <= 4'hF;
                work_rb    <= 4'hF;
                work_valc  <= 64'd0;
            end
            if (mem_req && mem_ack && !mem_err) begin
                addr_q     <= addr_q + 64'd1;
                work_icode <= fin_icode;
                work_ifun  <= fin_ifun;
                work_ra    <= fin_ra;
                work_rb    <= fin_rb;
                work_valc  <= fin_valc;
                len_q      <= fin_len;
                if (state == CONST) begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
            if (commit_ok) begin
                icode       <= fin_icode;
                ifun        <= fin_ifun;
                rA          <= fin_ra;
                rB          <= fin_rb;
                valC        <= fin_valc;
                valP        <= pc_q + {60'd0, fin_len};
                instr_valid <= (fin_icode <= 4'hB);
                imem_error  <= 1'b0;
            end
            if (abort) begin
                icode       <= 4'h1;
                ifun        <= 4'h0;
                rA          <= 4'hF;
                rB          <= 4'hF;
                valC        <= 64'd0;
                valP        <= pc_q;
                instr_valid <= 1'b1;
                imem_error  <= 1'b1;
            end
        end
    end

    // A pending request must not move or drop until memory accepts it.
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

    a_done_not_busy: assert property (@(posedge clk) disable iff (reset)
        done |-> !busy);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed cases plus randomized fetches
// compared every cycle against a byte-list reference model.
module tb_fetch_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] PC;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        mem_err;
    logic        busy;
    logic        done;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid, imem_error;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  prog [10];

    logic        m_active;
    logic        m_donecycle;
    int          m_consumed;
    int          m_len;
    logic [63:0] m_pc;
    logic [7:0]  m_bytes [10];
    logic [3:0]  r_icode, r_ifun, r_ra, r_rb;
    logic [63:0] r_valc, r_valp;
    logic        r_iv, r_err;

    fetch_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .PC         (PC),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .mem_err    (mem_err),
        .busy       (busy),
        .done       (done),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .instr_valid(instr_valid),
        .imem_error (imem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int lengthOf(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h3, 4'h4, 4'h5:       return 10;
            4'h7, 4'h8:             return 9;
            default:                return 1;
        endcase
    endfunction

    task automatic modelReset();
        m_active    = 1'b0;
        m_donecycle = 1'b0;
        m_consumed  = 0;
        m_len       = 1;
        m_pc        = 64'd0;
        r_icode = 4'h0; r_ifun = 4'h0; r_ra = 4'hF; r_rb = 4'hF;
        r_valc  = 64'd0; r_valp = 64'd0; r_iv = 1'b1; r_err = 1'b0;
    endtask

    // Decode the complete byte list into the published result.
    task automatic modelFinish();
        int off;
        logic hasreg;
        hasreg  = (m_len == 2) || (m_len == 10);
        off     = hasreg ? 2 : 1;
        r_icode = m_bytes[0][7:4];
        r_ifun  = m_bytes[0][3:0];
        r_ra    = hasreg ? m_bytes[1][7:4] : 4'hF;
        r_rb    = hasreg ? m_bytes[1][3:0] : 4'hF;
        r_valc  = 64'd0;
        if (m_len >= 9) begin
            for (int k = 0; k < 8; k++) begin
                r_valc = r_valc | (64'(m_bytes[off + k]) << (8 * k));
            end
        end
        r_valp = m_pc + 64'(m_len);
        r_iv   = (r_icode <= 4'hB);
        r_err  = 1'b0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            modelReset();
        end else if (m_donecycle) begin
            m_donecycle = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active   = 1'b1;
                m_pc       = PC;
                m_consumed = 0;
            end
        end else if (mem_ack) begin
            if (mem_err) begin
                r_icode = 4'h1; r_ifun = 4'h0; r_ra = 4'hF; r_rb = 4'hF;
                r_valc  = 64'd0; r_valp = m_pc; r_iv = 1'b1; r_err = 1'b1;
                m_active    = 1'b0;
                m_donecycle = 1'b1;
            end else begin
                m_bytes[m_consumed] = mem_data;
                if (m_consumed == 0) m_len = lengthOf(mem_data[7:4]);
                m_consumed++;
                if (m_consumed == m_len) begin
                    modelFinish();
                    m_active    = 1'b0;
                    m_donecycle = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) modelReset();
        checkOutput("mem_req", mem_req, m_active);
        checkOutput("busy", busy, m_active);
        checkOutput("done", done, m_donecycle);
        if (reset) checkOutput("mem_addr_rst", mem_addr, 64'd0);
        else if (m_active) checkOutput("mem_addr", mem_addr, m_pc + 64'(m_consumed));
        checkOutput("icode", icode, r_icode);
        checkOutput("ifun", ifun, r_ifun);
        checkOutput("rA", rA, r_ra);
        checkOutput("rB", rB, r_rb);
        checkOutput("valC", valC, r_valc);
        checkOutput("valP", valP, r_valp);
        checkOutput("instr_valid", instr_valid, r_iv);
        checkOutput("imem_error", imem_error, r_err);
    end

    // Runs one fetch of prog[] at pc with ack delays in [dmin,dmax]; done_cyc is the
    // cycle (counted from the start edge) in which the model expects done.
    task automatic applyStimulus(input logic [63:0] pc, input int err_at, input int dmin,
                                 input int dmax, input int reset_at, output int done_cyc);
        int cyc;
        int wait_left;
        logic finished;
        done_cyc  = -1;
        finished  = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        PC        = pc;
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        wait_left = $urandom_range(dmax, dmin);
        cyc       = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            reset = (cyc == reset_at) && (m_active || m_donecycle);
            if (m_donecycle) done_cyc = cyc;
            if (!m_active && !m_donecycle && !reset) begin
                start    = 1'b0;
                mem_ack  = 1'b0;
                mem_err  = 1'b0;
                finished = 1'b1;
                break;
            end
            start = 1'($urandom_range(1, 0));
            PC    = {$urandom, $urandom};
            if (!m_active) begin
                mem_ack  = 1'b0;
                mem_err  = 1'b0;
                mem_data = 8'($urandom);
            end else if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_data  = prog[m_consumed];
                mem_err   = (m_consumed == err_at);
                wait_left = $urandom_range(dmax, dmin);
            end else begin
                mem_ack   = 1'b0;
                mem_data  = 8'($urandom);
                mem_err   = 1'($urandom_range(1, 0));
                wait_left--;
            end
        end
        if (!finished) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL timeout: fetch at %0h still running after %0d cycles", pc, cyc);
            reset = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic loadProg(input logic [79:0] bytes);
        for (int i = 0; i < 10; i++) prog[i] = bytes[79 - 8*i -: 8];
    endtask

    initial begin
        int dc;
        logic [63:0] pc;
        int err;
        int rst_at;

        reset = 1'b1; start = 1'b0; PC = 64'd0;
        mem_ack = 1'b0; mem_data = 8'd0; mem_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_rA", rA, 4'hF);
        checkOutput("rst_instr_valid", instr_valid, 1'b1);
        reset = 1'b0;

        loadProg(80'h30F30A00000000000000);
        applyStimulus(64'h100, -1, 0, 0, -1, dc);
        #1;
        checkOutput("t032_done_cycle", 64'(dc), 64'd11);
        checkOutput("t032_icode", icode, 4'h3);
        checkOutput("t032_rB", rB, 4'h3);
        checkOutput("t032_valC", valC, 64'd10);
        checkOutput("t032_valP", valP, 64'h10A);

        loadProg(80'h74400000000000000000);
        applyStimulus(64'h20, -1, 0, 0, -1, dc);
        #1;
        checkOutput("t033_done_cycle", 64'(dc), 64'd10);
        checkOutput("t033_ifun", ifun, 4'h4);
        checkOutput("t033_rA", rA, 4'hF);
        checkOutput("t033_valC", valC, 64'h40);
        checkOutput("t033_valP", valP, 64'h29);

        loadProg(80'h90000000000000000000);
        applyStimulus(64'h90, -1, 3, 3, -1, dc);
        #1;
        checkOutput("t034_done_cycle", 64'(dc), 64'd5);
        checkOutput("t034_icode", icode, 4'h9);
        checkOutput("t034_valP", valP, 64'h91);

        loadProg(80'hC0000000000000000000);
        applyStimulus(64'h500, -1, 0, 1, -1, dc);
        #1;
        checkOutput("t035a_instr_valid", instr_valid, 1'b0);
        checkOutput("t035a_valP", valP, 64'h501);

        loadProg(80'hF0000000000000000000);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0, -1, dc);
        #1;
        checkOutput("t035b_valP", valP, 64'd0);
        checkOutput("t035b_instr_valid", instr_valid, 1'b0);

        loadProg(80'h4012AABBCCDDEEFF1122);
        applyStimulus(64'h40, 2, 0, 0, -1, dc);
        #1;
        checkOutput("t036_done_cycle", 64'(dc), 64'd4);
        checkOutput("t036_imem_error", imem_error, 1'b1);
        checkOutput("t036_icode", icode, 4'h1);
        checkOutput("t036_valP", valP, 64'h40);

        loadProg(80'h30F30A00000000000000);
        applyStimulus(64'h100, -1, 0, 0, 5, dc);
        #1;
        checkOutput("t037_mem_req", mem_req, 1'b0);
        checkOutput("t037_icode", icode, 4'h0);
        checkOutput("t037_valP", valP, 64'd0);
        loadProg(80'h74400000000000000000);
        applyStimulus(64'h20, -1, 0, 0, -1, dc);
        #1;
        checkOutput("t037_refetch_valP", valP, 64'h29);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 10; i++) prog[i] = 8'($urandom);
            pc = {$urandom, $urandom};
            if (t % 8 == 0) pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7, 0));
            err    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(9, 0)) : -1;
            rst_at = ($urandom_range(9, 0) == 0) ? int'($urandom_range(8, 1)) : -1;
            applyStimulus(pc, err, 0, int'($urandom_range(2, 0)), rst_at, dc);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
